multicast_sender: RTL



---
 rtl/multicast_sender.sv | 90 +++++++++
 1 files changed

// File: rtl/multicast_sender.sv
// multicast_sender: FIFO-buffered initiator for the tag-addressed multicast bus; optional stall timeout under MC_SENDER_TIMEOUT_EN
module multicast_sender #(
  parameter int ADDRESS_WIDTH  = 4,
  parameter int BITWIDTH       = 16,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          rstb,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ADDRESS_WIDTH-1:0]      in_tag,
  input  logic [BITWIDTH-1:0]           in_data,
  output logic                          bus_enable,
  input  logic                          bus_ready,
  output logic [ADDRESS_WIDTH-1:0]      bus_tag,
  output logic [BITWIDTH-1:0]           bus_value,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          idle,
  output logic                          err_timeout
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDRESS_WIDTH + BITWIDTH;
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nx;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [ADDRESS_WIDTH-1:0] out_tag;
  logic [BITWIDTH-1:0] out_data;
  logic push, pop, done, drop, empty;
  assign empty      = count == '0;
  assign in_ready   = count != CW'(FIFO_DEPTH);
  assign push       = in_valid & in_ready;
  assign done       = (state == SEND) & (bus_ready | drop);
  assign pop        = ~empty & ((state == IDLE) | done);
  assign fifo_count = count;
  assign idle       = empty & (state == IDLE);
`ifdef MC_SENDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  logic err_q;
  assign drop        = (state == SEND) & ~bus_ready & (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign err_timeout = err_q;
  // stall counter restarts whenever a packet finishes or a new one loads; error is sticky
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      tcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      tcnt  <= (done | pop) ? '0 : ((state == SEND) & ~bus_ready) ? tcnt + 1'b1 : tcnt;
      err_q <= err_q | drop;
    end
`else
  assign drop        = 1'b0;
  assign err_timeout = 1'b0;
`endif
  // state register
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) state <= IDLE;
    else state <= state_nx;
  // a fresh packet is taken whenever the bus is free or just finished
  always_comb
    state_nx = ((state == IDLE) | done) ? (empty ? IDLE : SEND) : state;
  // bus carries the output register only while enabled, zeros otherwise
  always_comb begin
    bus_enable = state == SEND;
    bus_tag    = bus_enable ? out_tag : '0;
    bus_value  = bus_enable ? out_data : '0;
  end
  // FIFO pointers and occupancy; full blocks push even if a pop happens
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(push) - CW'(pop);
    end
  // FIFO storage needs no reset since occupancy gates every read
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {in_tag, in_data};
  // output register holds the packet on the bus until it completes
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) {out_tag, out_data} <= '0;
    else if (pop) {out_tag, out_data} <= mem[rd_ptr];
endmodule
